move_repeater: RTL and testbench

//  Input conditioner between keyboard_tracker (held-level a/d/space) and control.

---
 rtl/move_repeater_pkg.sv | 35 +++
 rtl/move_repeater_timer.sv | 39 +++
 rtl/move_repeater.sv | 187 ++++++++++++++++++
 tb/tb_move_repeater.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/move_repeater_pkg.sv
// ---------------------------------------------------------------------------
// move_repeater_pkg
//  Shared definitions for the move repeater and its consumers.
//  - OP_* : 2-bit move request codes carried on req_op.
//  - h_state_t : horizontal auto-shift FSM states.
//  - select_op : maps the pending store to the request presented to control.
// ---------------------------------------------------------------------------
package move_repeater_pkg;

   localparam logic [1:0] OP_NONE   = 2'b00;
   localparam logic [1:0] OP_LEFT   = 2'b01;
   localparam logic [1:0] OP_RIGHT  = 2'b10;
   localparam logic [1:0] OP_ROTATE = 2'b11;

   typedef enum logic [1:0] {
      H_IDLE   = 2'd0,
      H_DELAY  = 2'd1,
      H_REPEAT = 2'd2
   } h_state_t;

   // Rotate outranks a pending horizontal request. A horizontal request
   // encodes its direction as {dir, ~dir}, so dir=0 is LEFT and dir=1 is RIGHT.
   function automatic logic [1:0] select_op(input logic pend_r,
                                            input logic pend_h,
                                            input logic h_dir);
      if (pend_r) begin
         return OP_ROTATE;
      end else if (pend_h) begin
         return {h_dir, ~h_dir};
      end else begin
         return OP_NONE;
      end
   endfunction

endpackage

// File: rtl/move_repeater_timer.sv
// ---------------------------------------------------------------------------
// move_repeater_timer
//  Down-counter that paces the delayed auto-shift and auto-repeat intervals.
//  Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset, clears the count
//   load     in   load 'value' this cycle (has priority over dec)
//   value    in   CNT_W reload value
//   dec      in   decrement this cycle; holds at zero
//   done     out  count is zero
// ---------------------------------------------------------------------------
module move_repeater_timer #(
   parameter int CNT_W = 23
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             dec,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // A load restarts an interval; decrementing stops at zero so a stray dec
   // after expiry cannot wrap the counter around to its maximum.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/move_repeater.sv
// ---------------------------------------------------------------------------
// move_repeater
//  Input conditioner between keyboard_tracker and control. Turns held key
//  levels into discrete move requests: left/right shift once on press, then
//  auto-shift after DAS_CYCLES and repeat every ARR_CYCLES; rotate fires once
//  per press. Requests wait in a two-slot pending store (one rotate slot, one
//  horizontal slot) that control drains with a valid/ready handshake.
//  Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   enable     in   game active; low flushes pending requests and idles
//   left       in   held level
//   right      in   held level
//   rotate     in   held level
//   req_valid  out  a move request is pending
//   req_op     out  OP_LEFT/OP_RIGHT/OP_ROTATE, OP_NONE when not valid
//   req_ready  in   control accepts the presented request this cycle
// ---------------------------------------------------------------------------
module move_repeater
   import move_repeater_pkg::*;
#(
   parameter int DAS_CYCLES = 8_000_000,
   parameter int ARR_CYCLES = 2_500_000,
   parameter int CNT_W      = 23
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       left,
   input  logic       right,
   input  logic       rotate,
   output logic       req_valid,
   output logic [1:0] req_op,
   input  logic       req_ready
);

   localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_CYCLES - 1);

   logic             left_q;
   logic             right_q;
   logic             rotate_q;
   logic             hold;
   logic             press;

   h_state_t         state;
   h_state_t         state_nx;
   logic             h_event;
   logic             r_event;

   logic             t_load;
   logic             t_dec;
   logic [CNT_W-1:0] t_value;
   logic             t_done;

   logic             pend_r;
   logic             pend_h;
   logic             h_dir;
   logic             pend_r_nx;
   logic             pend_h_nx;
   logic             h_dir_nx;

   // Exactly one horizontal key must be held. Because hold already excludes
   // both keys being down, a press is either the held key rising or the
   // opposite key having just been released (a one-cycle direction swap
   // satisfies both and also counts as a fresh press).
   assign hold  = left ^ right;
   assign press = hold & ((left  & (~left_q  | right_q)) |
                          (right & (~right_q | left_q)));

   assign r_event = enable & rotate & ~rotate_q;

   move_repeater_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (t_load),
      .value   (t_value),
      .dec     (t_dec),
      .done    (t_done)
   );

   // Horizontal next-state decode. A press always restarts the DAS interval
   // regardless of the current state; losing the single-key hold drops back
   // to idle without an event. Otherwise the timer paces DELAY then REPEAT.
   always_comb begin
      state_nx = state;
      h_event  = 1'b0;
      h_dir_nx = h_dir;
      t_load   = 1'b0;
      t_dec    = 1'b0;
      t_value  = DAS_LOAD;
      if (!enable) begin
         state_nx = H_IDLE;
      end else if (press) begin
         state_nx = H_DELAY;
         h_event  = 1'b1;
         h_dir_nx = right;
         t_load   = 1'b1;
         t_value  = DAS_LOAD;
      end else if (!hold) begin
         state_nx = H_IDLE;
      end else begin
         case (state)
            H_DELAY: begin
               if (t_done) begin
                  h_event  = 1'b1;
                  t_load   = 1'b1;
                  t_value  = ARR_LOAD;
                  state_nx = H_REPEAT;
               end else begin
                  t_dec = 1'b1;
               end
            end
            H_REPEAT: begin
               if (t_done) begin
                  h_event = 1'b1;
                  t_load  = 1'b1;
                  t_value = ARR_LOAD;
               end else begin
                  t_dec = 1'b1;
               end
            end
            default: begin
               state_nx = H_IDLE;
            end
         endcase
      end
   end

   // Pending store update. A handshake only clears the slot being presented
   // (rotate first). New events are applied after the clear so that a slot
   // set and accepted in the same cycle stays pending. A second horizontal
   // event while pending simply refreshes h_dir, and a second rotate is
   // absorbed by the already-set flag.
   always_comb begin
      pend_r_nx = pend_r;
      pend_h_nx = pend_h;
      if (!enable) begin
         pend_r_nx = 1'b0;
         pend_h_nx = 1'b0;
      end else begin
         if (req_ready && pend_r) begin
            pend_r_nx = 1'b0;
         end
         if (req_ready && !pend_r && pend_h) begin
            pend_h_nx = 1'b0;
         end
         if (r_event) begin
            pend_r_nx = 1'b1;
         end
         if (h_event) begin
            pend_h_nx = 1'b1;
         end
      end
   end

   // State, key history, pending store and the registered request outputs.
   // Key history tracks the keys even while disabled, so keys held across
   // an enable rise need a release and re-press before they fire. History
   // clears in reset, so a key held through reset presses once released.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         left_q    <= 1'b0;
         right_q   <= 1'b0;
         rotate_q  <= 1'b0;
         state     <= H_IDLE;
         pend_r    <= 1'b0;
         pend_h    <= 1'b0;
         h_dir     <= 1'b0;
         req_valid <= 1'b0;
         req_op    <= OP_NONE;
      end else begin
         left_q    <= left;
         right_q   <= right;
         rotate_q  <= rotate;
         state     <= state_nx;
         pend_r    <= pend_r_nx;
         pend_h    <= pend_h_nx;
         h_dir     <= h_dir_nx;
         req_valid <= pend_r_nx | pend_h_nx;
         req_op    <= select_op(pend_r_nx, pend_h_nx, h_dir_nx);
      end
   end

endmodule

// File: tb/tb_move_repeater.sv
// ---------------------------------------------------------------------------
// tb_move_repeater
//  Directed bench for move_repeater with DAS_CYCLES=4, ARR_CYCLES=2.
//  Inputs change just after a falling edge; outputs are read there too.
//  Every accepted request is matched against a queue of expected ops.
// ---------------------------------------------------------------------------
module tb_move_repeater;
   import move_repeater_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic       left;
   logic       right;
   logic       rotate;
   logic       req_valid;
   logic [1:0] req_op;
   logic       req_ready;

   int         checks;
   int         errors;
   logic [1:0] sb[$];

   move_repeater #(
      .DAS_CYCLES (4),
      .ARR_CYCLES (2),
      .CNT_W      (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .left      (left),
      .right     (right),
      .rotate    (rotate),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_ready (req_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [1:0] got,
                               input logic [1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // A request seen valid with ready high here is taken on the coming edge,
   // so it is popped from the expected queue and compared now.
   task automatic apply_stimulus();
      logic [1:0] exp;
      if (reset_n && enable && req_valid && req_ready) begin
         checks++;
         assert (sb.size() > 0)
         else begin
            errors++;
            $error("[TB] FAIL sb_underflow: observed op=%b expected none", req_op);
         end
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            check_output("sb_op", req_op, exp);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_n   = 1'b0;
      enable    = 1'b1;
      left      = 1'b1;
      right     = 1'b0;
      rotate    = 1'b0;
      req_ready = 1'b1;

      // 1: left held through reset gives exactly one LEFT after release
      @(posedge clk);
      @(negedge clk);
      check_output("reset_valid_0", {1'b0, req_valid}, 2'b00);
      check_output("reset_op_0", req_op, OP_NONE);
      apply_stimulus();
      check_output("reset_valid_1", {1'b0, req_valid}, 2'b00);
      check_output("reset_op_1", req_op, OP_NONE);
      reset_n = 1'b1;
      sb.push_back(OP_LEFT);
      apply_stimulus();
      check_output("post_reset_valid", {1'b0, req_valid}, 2'b01);
      check_output("post_reset_op", req_op, OP_LEFT);
      left = 1'b0;
      apply_stimulus();
      check_output("post_reset_idle", {1'b0, req_valid}, 2'b00);
      apply_stimulus();

      // 2: hold left 12 cycles: press, DAS 4, then ARR 2
      for (int i = 0; i < 5; i++) sb.push_back(OP_LEFT);
      for (int c = 0; c < 12; c++) begin
         left = 1'b1;
         apply_stimulus();
         check_output($sformatf("hold_left_c%0d", c + 1), {1'b0, req_valid},
                      ((c + 1 == 1) || (c + 1 == 5) || (c + 1 == 7) ||
                       (c + 1 == 9) || (c + 1 == 11)) ? 2'b01 : 2'b00);
      end
      left = 1'b0;
      for (int c = 12; c < 15; c++) begin
         apply_stimulus();
         check_output($sformatf("left_released_c%0d", c + 1),
                      {1'b0, req_valid}, 2'b00);
      end

      // 3: both keys suppress; dropping left presses RIGHT and restarts DAS
      for (int c = 0; c < 14; c++) begin
         left  = (c < 6);
         right = (c >= 2) && (c <= 11);
         if (c == 0) sb.push_back(OP_LEFT);
         if (c == 6) sb.push_back(OP_RIGHT);
         if (c == 10) sb.push_back(OP_RIGHT);
         apply_stimulus();
         check_output($sformatf("both_keys_c%0d", c + 1), {1'b0, req_valid},
                      ((c + 1 == 1) || (c + 1 == 7) || (c + 1 == 11)) ?
                      2'b01 : 2'b00);
      end
      left  = 1'b0;
      right = 1'b0;
      apply_stimulus();

      // 4: rotate and left together under backpressure; rotate wins
      rotate    = 1'b1;
      left      = 1'b1;
      req_ready = 1'b0;
      sb.push_back(OP_ROTATE);
      sb.push_back(OP_LEFT);
      apply_stimulus();
      check_output("arb_op_c1", req_op, OP_ROTATE);
      left = 1'b0;
      apply_stimulus();
      check_output("arb_op_c2", req_op, OP_ROTATE);
      apply_stimulus();
      check_output("arb_op_c3", req_op, OP_ROTATE);
      req_ready = 1'b1;
      apply_stimulus();
      check_output("arb_left_valid", {1'b0, req_valid}, 2'b01);
      check_output("arb_left_op", req_op, OP_LEFT);
      apply_stimulus();
      check_output("arb_drained", {1'b0, req_valid}, 2'b00);
      rotate = 1'b0;
      apply_stimulus();
      apply_stimulus();

      // 5: held right coalesces into one RIGHT; second rotate is dropped
      req_ready = 1'b0;
      sb.push_back(OP_RIGHT);
      for (int c = 0; c < 11; c++) begin
         right  = (c < 10);
         rotate = (c == 2) || (c == 4);
         // the rotate outranks the RIGHT already waiting, so it leaves first
         if (c == 2) sb.push_front(OP_ROTATE);
         apply_stimulus();
         check_output($sformatf("coalesce_c%0d", c + 1), req_op,
                      (c + 1 >= 3) ? OP_ROTATE : OP_RIGHT);
      end
      right     = 1'b0;
      rotate    = 1'b0;
      req_ready = 1'b1;
      apply_stimulus();
      check_output("coalesce_right_op", req_op, OP_RIGHT);
      apply_stimulus();
      check_output("coalesce_no_dup_0", {1'b0, req_valid}, 2'b00);
      apply_stimulus();
      check_output("coalesce_no_dup_1", {1'b0, req_valid}, 2'b00);

      // 6: enable drop flushes; held keys wait for a re-press
      req_ready = 1'b0;
      left      = 1'b1;
      rotate    = 1'b1;
      apply_stimulus();
      check_output("en_pending_op", req_op, OP_ROTATE);
      enable = 1'b0;
      apply_stimulus();
      check_output("en_flushed", {1'b0, req_valid}, 2'b00);
      enable    = 1'b1;
      req_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         apply_stimulus();
         check_output($sformatf("en_held_c%0d", c), {1'b0, req_valid}, 2'b00);
      end
      left   = 1'b0;
      rotate = 1'b0;
      apply_stimulus();
      left = 1'b1;
      sb.push_back(OP_LEFT);
      apply_stimulus();
      check_output("en_repress_op", req_op, OP_LEFT);
      left = 1'b0;
      apply_stimulus();
      check_output("en_repress_done", {1'b0, req_valid}, 2'b00);

      // Reset in the middle of a pending request
      req_ready = 1'b0;
      rotate    = 1'b1;
      apply_stimulus();
      check_output("midreset_pending", {1'b0, req_valid}, 2'b01);
      reset_n = 1'b0;
      rotate  = 1'b0;
      apply_stimulus();
      check_output("midreset_valid", {1'b0, req_valid}, 2'b00);
      check_output("midreset_op", req_op, OP_NONE);
      reset_n = 1'b1;
      apply_stimulus();
      check_output("midreset_after", {1'b0, req_valid}, 2'b00);

      checks++;
      assert (sb.size() == 0)
      else begin
         errors++;
         $error("[TB] FAIL sb_leftover: observed=%0d expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
